// File: rtl/div_job_ctrl.sv
// Job sequencer for an external 8-by-4 restoring divider: queues jobs, resolves
// divide-by-zero and quotient-overflow locally, and runs legal jobs one at a time.
module div_job_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_dividend,
    input  logic [3:0] in_divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_quotient,
    output logic [3:0] out_remainder,
    output logic       out_dz,
    output logic       out_ovf,
    output logic       div_start,
    output logic [7:0] div_word1,
    output logic [3:0] div_word2,
    input  logic       div_ready,
    input  logic [3:0] div_quotient,
    input  logic [3:0] div_remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [11:0]      fifo_mem [FIFO_DEPTH];

    logic       out_valid_q, out_valid_d;
    logic [3:0] out_quotient_q, out_quotient_d;
    logic [3:0] out_remainder_q, out_remainder_d;
    logic       out_dz_q, out_dz_d;
    logic       out_ovf_q, out_ovf_d;

    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       has_job;
    logic [7:0] head_dividend;
    logic [3:0] head_divisor;

    assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    // A job being pushed this cycle is visible at the head next cycle, so it
    // lets IDLE/OUT move straight to CHECK.
    assign has_job    = !fifo_empty || push;

    assign head_dividend = fifo_mem[rd_ptr_q][11:4];
    assign head_divisor  = fifo_mem[rd_ptr_q][3:0];
    assign div_word1     = head_dividend;
    assign div_word2     = head_divisor;

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_dz        = out_dz_q;
    assign out_ovf       = out_ovf_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_dividend, in_divisor};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        div_start       = 1'b0;
        out_valid_d     = out_valid_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_dz_d        = out_dz_q;
        out_ovf_d       = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (has_job && !out_valid_q) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (head_divisor == 4'd0) begin
                    out_quotient_d  = 4'hF;
                    out_remainder_d = head_dividend[7:4];
                    out_dz_d        = 1'b1;
                    out_ovf_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    pop             = 1'b1;
                    state_d         = S_OUT;
                end else if (head_dividend[7:4] >= head_divisor) begin
                    // Quotient would need more than 4 bits.
                    out_quotient_d  = 4'hF;
                    out_remainder_d = head_dividend[7:4];
                    out_dz_d        = 1'b0;
                    out_ovf_d       = 1'b1;
                    out_valid_d     = 1'b1;
                    pop             = 1'b1;
                    state_d         = S_OUT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = div_ready;
                if (div_ready) begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!div_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (div_ready) begin
                    out_quotient_d  = div_quotient;
                    out_remainder_d = div_remainder;
                    out_dz_d        = 1'b0;
                    out_ovf_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    pop             = 1'b1;
                    state_d         = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = has_job ? S_CHECK : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= 4'd0;
            out_remainder_q <= 4'd0;
            out_dz_q        <= 1'b0;
            out_ovf_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            out_valid_q     <= out_valid_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_dz_q        <= out_dz_d;
            out_ovf_q       <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_div_job_ctrl.sv
// Bench for div_job_ctrl: a behavioural 4-busy-cycle divider, a scoreboard fed on
// input handshakes, and a monitor that pops and compares on output handshakes.
module tb_div_job_ctrl;

    localparam int DIV_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_dividend = 8'd0;
    logic [3:0] in_divisor = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic       out_dz;
    logic       out_ovf;
    logic       div_start;
    logic [7:0] div_word1;
    logic [3:0] div_word2;
    logic       div_ready;
    logic [3:0] div_quotient;
    logic [3:0] div_remainder;

    always #5 clk = ~clk;

    div_job_ctrl #(.FIFO_DEPTH(2), .PTR_W(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_dz       (out_dz),
        .out_ovf      (out_ovf),
        .div_start    (div_start),
        .div_word1    (div_word1),
        .div_word2    (div_word2),
        .div_ready    (div_ready),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    // Divider model: busy for DIV_CYCLES cycles after an accepted start.
    logic       div_busy;
    int         div_cnt;
    logic [7:0] div_a;
    logic [3:0] div_b;
    assign div_ready = !div_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_busy      <= 1'b0;
            div_cnt       <= 0;
            div_a         <= 8'd0;
            div_b         <= 4'd1;
            div_quotient  <= 4'd0;
            div_remainder <= 4'd0;
        end else if (div_busy) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_busy      <= 1'b0;
                div_quotient  <= (div_b == 4'd0) ? 4'hF : 4'(int'(div_a) / int'(div_b));
                div_remainder <= (div_b == 4'd0) ? 4'hF : 4'(int'(div_a) % int'(div_b));
            end
        end else if (div_start) begin
            div_busy <= 1'b1;
            div_cnt  <= DIV_CYCLES;
            div_a    <= div_word1;
            div_b    <= div_word2;
        end
    end

    int total = 0;
    int bad = 0;
    int starts = 0;
    int results = 0;
    int accepted = 0;
    logic [9:0] exp_q[$];
    logic       hold_pending = 1'b0;
    logic [9:0] held = 10'd0;
    logic       rand_ready = 1'b0;
    logic       bp_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {quotient, remainder, dz, ovf} from plain integer division.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [3:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) return {4'hF, 4'(ia / 16), 2'b10};
        if (ia / ib > 15) return {4'hF, 4'(ia / 16), 2'b01};
        return {4'(ia / ib), 4'(ia % ib), 2'b00};
    endfunction

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        logic [9:0] cur;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pending = 1'b0;
            end else begin
                cur = {out_quotient, out_remainder, out_dz, out_ovf};
                if (div_start) begin
                    starts++;
                    check("start_needs_ready", int'(div_ready), 1);
                end
                if (hold_pending) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_data", int'(cur), int'(held));
                end
                hold_pending = out_valid && !out_ready;
                held = cur;
                if (out_valid && out_ready) begin
                    results++;
                    check("result_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("result", int'(cur), int'(e));
                    end
                    $display("result q=%0d r=%0d dz=%0b ovf=%0b", out_quotient, out_remainder,
                             out_dz, out_ovf);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_dividend, in_divisor));
                    accepted++;
                end
            end
        end
    end

    // Random backpressure, driven just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic push_job(input logic [7:0] a, input logic [3:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_dividend = a;
        in_divisor = b;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("push_accept", int'(ok), 1);
    endtask

    task automatic wait_idle(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles && !ok; n++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !out_valid;
        end
        check("drain", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic latency_job(input logic [7:0] a, input logic [3:0] b,
                               input int exp_lat, input int exp_starts, input string tag);
        int s0;
        int n;
        s0 = starts;
        push_job(a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_starts"}, starts - s0, exp_starts);
        @(posedge clk);
        #1;
        wait_idle(100);
    endtask

    initial begin
        int acc0;
        int r0;
        int s0;
        int legal;
        int ok;
        logic [7:0] a;
        logic [3:0] b;
        logic [9:0] m;

        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(out_quotient), 0);
        check("rst_remainder", int'(out_remainder), 0);
        check("rst_flags", int'({out_dz, out_ovf}), 0);
        check("rst_div_start", int'(div_start), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        latency_job(8'd100, 4'd7, 8, 1, "legal");
        latency_job(8'd37, 4'd0, 2, 0, "dz");
        latency_job(8'hF0, 4'd3, 2, 0, "ovf");

        // Backpressure with a full queue.
        out_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                push_job(8'd100, 4'd7);
                push_job(8'd45, 4'd6);
                push_job(8'd9, 4'd2);
                push_job(8'd8, 4'd3);
                bp_done = 1'b1;
            end
        join_none
        repeat (30) @(negedge clk);
        check("bp_accepted", accepted - acc0, 3);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_quotient", int'(out_quotient), 14);
        check("bp_remainder", int'(out_remainder), 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        ok = 0;
        for (int n = 0; n < 500 && ok == 0; n++) begin
            @(negedge clk);
            ok = int'(bp_done);
        end
        check("bp_pusher_done", ok, 1);
        @(posedge clk);
        #1;
        wait_idle(200);

        // Push in the same cycle the divide-by-zero head pops out of CHECK.
        push_job(8'd37, 4'd0);
        push_job(8'd100, 4'd7);
        @(negedge clk);
        check("pushpop_count", int'(dut.count_q), 1);
        @(posedge clk);
        #1;
        wait_idle(200);

        // Reset while the divider is working, with a second job queued.
        push_job(8'd100, 4'd7);
        push_job(8'd45, 4'd6);
        ok = 0;
        for (int n = 0; n < 20 && ok == 0; n++) begin
            @(negedge clk);
            ok = int'(!div_ready);
        end
        check("midop_div_busy", ok, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        r0 = results;
        repeat (2) @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_count", int'(dut.count_q), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (12) @(negedge clk);
        check("midrst_no_result", results - r0, 0);
        @(posedge clk);
        #1;
        push_job(8'd200, 4'd13);
        wait_idle(100);
        check("midrst_new_job", results - r0, 1);

        // Randomised jobs with random backpressure.
        s0 = starts;
        legal = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            m = model(a, b);
            if (m[1:0] == 2'b00) legal++;
            push_job(a, b);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(3000);
        check("random_starts", starts - s0, legal);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
